// File: rtl/tdm_demux_2ch_if.sv
// tdm_demux_2ch_if: multiplexed sample bus in, restored x/y channels out.
// master drives the shared stream; slave is the demultiplexer.
interface tdm_demux_2ch_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic             x_valid;
    logic             y_valid;
    logic             pair_valid;
    logic             err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output din, din_valid, sync,
        input  x_out, y_out, x_valid, y_valid,
        input  pair_valid, err, frame_cnt
    );

    modport slave (
        input  din, din_valid, sync,
        output x_out, y_out, x_valid, y_valid,
        output pair_valid, err, frame_cnt
    );
endinterface

// File: rtl/tdm_demux_2ch.sv
// tdm_demux_2ch: splits an X/Y time-division stream back into two held
// channels, flags complete pairs and framing errors, counts good frames.
module tdm_demux_2ch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    tdm_demux_2ch_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXP_Y = 2'd1,
        EXP_X = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             xv_q, xv_d;
    logic             yv_q, yv_d;
    logic             pv_q, pv_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xv_q    <= 1'b0;
            yv_q    <= 1'b0;
            pv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xv_q    <= xv_d;
            yv_q    <= yv_d;
            pv_q    <= pv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xv_d    = 1'b0;
        yv_d    = 1'b0;
        pv_d    = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (bus.din_valid) begin
            unique case (state_q)
                IDLE: begin
                    // Unsynced non-sync samples are expected before lock.
                    if (bus.sync) begin
                        x_d     = bus.din;
                        xv_d    = 1'b1;
                        state_d = EXP_Y;
                    end
                end
                EXP_Y: begin
                    if (bus.sync) begin
                        x_d   = bus.din;
                        xv_d  = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        y_d     = bus.din;
                        yv_d    = 1'b1;
                        pv_d    = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = EXP_X;
                    end
                end
                EXP_X: begin
                    if (bus.sync) begin
                        x_d     = bus.din;
                        xv_d    = 1'b1;
                        state_d = EXP_Y;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.x_valid    = xv_q;
    assign bus.y_valid    = yv_q;
    assign bus.pair_valid = pv_q;
    assign bus.err        = err_q;
    assign bus.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// tb_tdm_demux_2ch: scoreboard bench for the two-channel TDM demultiplexer.
// Each driven cycle queues its expected outputs; a monitor checks them.
module tb_tdm_demux_2ch;

    logic clk;
    logic reset_n;

    tdm_demux_2ch_if #(.WIDTH(8), .CNT_W(8)) bus ();

    tdm_demux_2ch #(.WIDTH(8), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       xv;
        logic       yv;
        logic       pv;
        logic       er;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    exp_t mon_got;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = unlocked, 1 = awaiting Y, 2 = awaiting X
    int         m_st;
    logic [7:0] m_x;
    logic [7:0] m_y;
    logic [7:0] m_cnt;

    always @(posedge clk) begin
        #1;
        if (reset_n && sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_got = '{x: bus.x_out, y: bus.y_out,
                        xv: bus.x_valid, yv: bus.y_valid,
                        pv: bus.pair_valid, er: bus.err,
                        cnt: bus.frame_cnt};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL sb t=%0t got x=%h y=%h xv%b yv%b pv%b err%b cnt=%0d exp x=%h y=%h xv%b yv%b pv%b err%b cnt=%0d",
                         $time, mon_got.x, mon_got.y, mon_got.xv, mon_got.yv,
                         mon_got.pv, mon_got.er, mon_got.cnt,
                         mon_exp.x, mon_exp.y, mon_exp.xv, mon_exp.yv,
                         mon_exp.pv, mon_exp.er, mon_exp.cnt);
            end
        end
    end

    task automatic send(input logic v, input logic s, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        bus.din_valid = v;
        bus.sync      = s;
        bus.din       = d;
        e = '{x: m_x, y: m_y, xv: 1'b0, yv: 1'b0, pv: 1'b0, er: 1'b0, cnt: m_cnt};
        if (v) begin
            if (s) begin
                e.xv = 1'b1;
                e.er = (m_st == 1);
                m_x  = d;
                e.x  = d;
                m_st = 1;
            end else if (m_st == 1) begin
                m_y   = d;
                e.y   = d;
                e.yv  = 1'b1;
                e.pv  = 1'b1;
                m_cnt = m_cnt + 8'd1;
                e.cnt = m_cnt;
                m_st  = 2;
            end else if (m_st == 2) begin
                e.er = 1'b1;
                m_st = 0;
            end
        end
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.din_valid = 1'b0;
        bus.sync = 1'b0;
        sb.delete();
        m_st = 0; m_x = '0; m_y = '0; m_cnt = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.x_out, bus.y_out, bus.frame_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got x=%h y=%h cnt=%0d want 0",
                     bus.x_out, bus.y_out, bus.frame_cnt);
        end
        checks++;
        if ({bus.x_valid, bus.y_valid, bus.pair_valid, bus.err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 0000",
                     {bus.x_valid, bus.y_valid, bus.pair_valid, bus.err});
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        send(1, 1, 8'h11);
        send(1, 0, 8'h22);
        send(1, 1, 8'h33);
        send(1, 0, 8'h44);
        send(0, 0, 8'h00);
        checks++;
        if (bus.x_out !== 8'h33 || bus.y_out !== 8'h44 || bus.frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL basic got x=%h y=%h cnt=%0d want 33 44 2",
                     bus.x_out, bus.y_out, bus.frame_cnt);
        end
    endtask

    task automatic test_prelock();
        do_reset();
        send(1, 0, 8'hAA);
        send(1, 0, 8'hBB);
        send(1, 1, 8'h01);
        send(1, 0, 8'h02);
        send(0, 0, 8'h00);
        checks++;
        if (bus.x_out !== 8'h01 || bus.y_out !== 8'h02 || bus.frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL prelock got x=%h y=%h cnt=%0d want 01 02 1",
                     bus.x_out, bus.y_out, bus.frame_cnt);
        end
    endtask

    task automatic test_errors();
        do_reset();
        send(1, 1, 8'h10);
        send(1, 1, 8'h20);
        send(1, 0, 8'h30);
        send(0, 0, 8'h00);
        checks++;
        if (bus.x_out !== 8'h20 || bus.y_out !== 8'h30 || bus.frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL resync got x=%h y=%h cnt=%0d want 20 30 1",
                     bus.x_out, bus.y_out, bus.frame_cnt);
        end
        send(1, 0, 8'h55);
        send(0, 1, 8'h00);
        checks++;
        if (bus.err !== 1'b1 || bus.y_out !== 8'h30) begin
            errors++;
            $display("FAIL unexp_y got err=%b y=%h want 1 30", bus.err, bus.y_out);
        end
        // Back in IDLE: a further non-sync sample is silently dropped
        send(1, 0, 8'h66);
        send(0, 0, 8'h00);
        checks++;
        if (bus.err !== 1'b0 || bus.y_out !== 8'h30) begin
            errors++;
            $display("FAIL idle_drop got err=%b y=%h want 0 30", bus.err, bus.y_out);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            d = 8'(p * 16 + 5);
            send(1, 1, d);
            repeat ($urandom_range(0, 3)) send(0, 1'($urandom), 8'($urandom));
            send(1, 0, ~d);
            repeat ($urandom_range(0, 3)) send(0, 1'($urandom), 8'($urandom));
        end
        send(0, 1, 8'h00);
        checks++;
        if (bus.x_out !== 8'h35 || bus.y_out !== 8'hCA || bus.frame_cnt !== 8'd4) begin
            errors++;
            $display("FAIL gaps got x=%h y=%h cnt=%0d want 35 ca 4",
                     bus.x_out, bus.y_out, bus.frame_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 257; i++) begin
            send(1, 1, 8'(i));
            send(1, 0, 8'(i + 1));
            if (i == 254) begin
                send(0, 0, 8'h00);
                checks++;
                if (bus.frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255 got %0d want 255", bus.frame_cnt);
                end
            end
        end
        send(0, 0, 8'h00);
        checks++;
        if (bus.frame_cnt !== 8'd1 || bus.err !== 1'b0 || bus.pair_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_1 got cnt=%0d err=%b pv=%b want 1 0 1",
                     bus.frame_cnt, bus.err, bus.pair_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(1, 1, 8'h77);
        send(0, 0, 8'h00);
        #3;
        reset_n = 1'b0;
        sb.delete();
        m_st = 0; m_x = '0; m_y = '0; m_cnt = '0;
        #1;
        checks++;
        if ({bus.x_out, bus.y_out, bus.frame_cnt} !== 24'h0 ||
            {bus.x_valid, bus.y_valid, bus.pair_valid, bus.err} !== 4'b0) begin
            errors++;
            $display("FAIL async_rst got x=%h y=%h cnt=%0d pulses=%b want 0",
                     bus.x_out, bus.y_out, bus.frame_cnt,
                     {bus.x_valid, bus.y_valid, bus.pair_valid, bus.err});
        end
        @(negedge clk);
        reset_n = 1'b1;
        send(1, 0, 8'h88);
        send(0, 0, 8'h00);
        checks++;
        if (bus.pair_valid !== 1'b0 || bus.y_out !== 8'h00 || bus.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst got pv=%b y=%h yv=%b want 0 00 0",
                     bus.pair_valid, bus.y_out, bus.y_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.sync = 1'b0;
        m_st = 0; m_x = '0; m_y = '0; m_cnt = '0;
        test_reset();
        test_basic();
        test_prelock();
        test_errors();
        test_gaps();
        test_wrap();
        test_async_reset();
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
